// File: rtl/mips_pkg.sv
// Shared MIPS instruction-format definitions: field positions, default NOP and a field-view struct.
package mips_pkg;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_MSB    = 25;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_MSB    = 15;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned SHAMT_MSB = 10;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned IMM_MSB   = 15;
    localparam int unsigned IMM_LSB   = 0;
    localparam int unsigned ADDR_MSB  = 25;
    localparam int unsigned ADDR_LSB  = 0;

    // sll r0,r0,0
    localparam logic [31:0] NOP_WORD_DFLT = 32'h0000_0000;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_fields_t;

    function automatic instr_fields_t decode_fields(input logic [31:0] instr);
        instr_fields_t f;
        f.opcode = instr[OP_MSB:OP_LSB];
        f.rs     = instr[RS_MSB:RS_LSB];
        f.rt     = instr[RT_MSB:RT_LSB];
        f.rd     = instr[RD_MSB:RD_LSB];
        f.shamt  = instr[SHAMT_MSB:SHAMT_LSB];
        f.funct  = instr[FUNCT_MSB:FUNCT_LSB];
        return f;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready register slice with a one-entry skid; in_ready is registered
// so no combinational path exists from out_ready back to the producer.
module pipe_skid_buf #(
    parameter int unsigned       WIDTH     = 64,
    parameter logic [WIDTH-1:0]  IDLE_DATA = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;

    logic accept_c;
    logic deliver_c;

    assign accept_c  = in_valid && !skid_valid_q;
    assign deliver_c = main_valid_q && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = IDLE_DATA;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || deliver_c) begin
            // Skid is only ever full while main is full, so it drains first.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept_c) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
                main_data_d  = IDLE_DATA;
            end
        end else if (accept_c) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= IDLE_DATA;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

endmodule

// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline register: flow-controlled skid slice, flush bubble insertion,
// instruction field decode and saturating stall/flush event counters.
module if_id_pipe_stage
    import mips_pkg::*;
#(
    parameter int unsigned        INSTR_W  = 32,
    parameter int unsigned        PC_W     = 32,
    parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(NOP_WORD_DFLT),
    parameter int unsigned        CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [5:0]         out_opcode,
    output logic [4:0]         out_rs,
    output logic [4:0]         out_rt,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_shamt,
    output logic [5:0]         out_funct,
    output logic [15:0]        out_imm16,
    output logic [25:0]        out_addr26,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam int unsigned BEAT_W = INSTR_W + PC_W;

    logic [BEAT_W-1:0] out_beat;
    logic [31:0]       instr32;
    instr_fields_t     fields;

    pipe_skid_buf #(
        .WIDTH     (BEAT_W),
        .IDLE_DATA ({NOP_WORD, PC_W'(0)})
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_instr, in_pc}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_beat)
    );

    assign out_instr = out_beat[BEAT_W-1:PC_W];
    assign out_pc    = out_beat[PC_W-1:0];

    // Field slices follow the held word, which is already NOP_WORD when idle.
    assign instr32    = 32'(out_instr);
    assign fields     = decode_fields(instr32);
    assign out_opcode = fields.opcode;
    assign out_rs     = fields.rs;
    assign out_rt     = fields.rt;
    assign out_rd     = fields.rd;
    assign out_shamt  = fields.shamt;
    assign out_funct  = fields.funct;
    assign out_imm16  = instr32[IMM_MSB:IMM_LSB];
    assign out_addr26 = instr32[ADDR_MSB:ADDR_LSB];

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (out_valid && !out_ready && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Directed bench for if_id_pipe_stage; a second instance with 4-bit counters checks saturation.
module tb_if_id_pipe_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;

    logic        in_ready, out_valid;
    logic [31:0] out_instr, out_pc;
    logic [5:0]  out_opcode, out_funct;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [15:0] out_imm16;
    logic [25:0] out_addr26;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_instr, s_out_pc;
    logic [5:0]  s_out_opcode, s_out_funct;
    logic [4:0]  s_out_rs, s_out_rt, s_out_rd, s_out_shamt;
    logic [15:0] s_out_imm16;
    logic [25:0] s_out_addr26;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_id_pipe_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_funct(out_funct), .out_imm16(out_imm16),
        .out_addr26(out_addr26), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    if_id_pipe_stage #(.CNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_instr(s_out_instr), .out_pc(s_out_pc),
        .out_opcode(s_out_opcode), .out_rs(s_out_rs), .out_rt(s_out_rt), .out_rd(s_out_rd),
        .out_shamt(s_out_shamt), .out_funct(s_out_funct), .out_imm16(s_out_imm16),
        .out_addr26(s_out_addr26), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        flush = 1'b0; out_ready = 1'b0;
        step(); step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'h0);
        chk("rst_out_pc",    64'(out_pc),    64'h0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);

        // Streaming: four lui-like addi words, one beat per cycle
        reset = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_instr = 32'h2008_0005 + 32'(i);
            in_pc    = 32'(4 * i);
            step();
            chk("strm_valid", 64'(out_valid), 64'd1);
            chk("strm_instr", 64'(out_instr), 64'(32'h2008_0005 + 32'(i)));
            chk("strm_pc",    64'(out_pc),    64'(4 * i));
            chk("strm_opcode", 64'(out_opcode), 64'd8);
            chk("strm_rt",    64'(out_rt),    64'd8);
            chk("strm_imm16", 64'(out_imm16), 64'(5 + i));
            chk("strm_in_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("strm_drain_valid", 64'(out_valid), 64'd0);
        chk("strm_drain_instr", 64'(out_instr), 64'h0);
        chk("strm_stall_cnt",   64'(stall_cnt), 64'd0);

        // Stall: A in main, B into skid, C held off until release
        in_valid = 1'b1; in_instr = 32'h8C22_0010; in_pc = 32'h100; out_ready = 1'b1;
        step();
        chk("stl_a_loaded", 64'(out_pc), 64'h100);
        out_ready = 1'b0; in_instr = 32'h8C23_0014; in_pc = 32'h104;
        step();
        chk("stl_in_ready_drop", 64'(in_ready), 64'd0);
        chk("stl_hold_a_pc", 64'(out_pc), 64'h100);
        in_instr = 32'h8C24_0018; in_pc = 32'h108;
        step();
        chk("stl_hold_a_instr", 64'(out_instr), 64'h8C22_0010);
        step();
        chk("stl_stall_cnt", 64'(stall_cnt), 64'd3);
        chk("stl_in_ready_low", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step();
        chk("stl_rel_b_instr", 64'(out_instr), 64'h8C23_0014);
        chk("stl_rel_b_pc",    64'(out_pc),    64'h104);
        chk("stl_rel_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("stl_rel_c_instr", 64'(out_instr), 64'h8C24_0018);
        chk("stl_rel_c_pc",    64'(out_pc),    64'h108);
        in_valid = 1'b0;
        step();
        chk("stl_done_valid", 64'(out_valid), 64'd0);
        chk("stl_done_cnt",   64'(stall_cnt), 64'd3);

        // Flush with skid full; the beat offered alongside the flush must vanish
        in_valid = 1'b1; in_instr = 32'h0085_1020; in_pc = 32'h200; out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_instr = 32'h00A6_1820; in_pc = 32'h204;
        step();
        chk("fl_skid_full", 64'(in_ready), 64'd0);
        chk("fl_stall_cnt_pre", 64'(stall_cnt), 64'd4);
        flush = 1'b1; in_instr = 32'h00C7_2020; in_pc = 32'h208;
        step();
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_out_pc",    64'(out_pc),    64'h0);
        chk("fl_out_instr", 64'(out_instr), 64'h0);
        chk("fl_out_funct", 64'(out_funct), 64'h0);
        chk("fl_in_ready",  64'(in_ready),  64'd1);
        chk("fl_flush_cnt", 64'(flush_cnt), 64'd1);
        chk("fl_stall_cnt", 64'(stall_cnt), 64'd4);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        chk("fl_no_ghost", 64'(out_valid), 64'd0);

        // Saturation: 20 more stall cycles take the 4-bit counter past all-ones
        in_valid = 1'b1; in_instr = 32'h3C01_ABCD; in_pc = 32'h300; out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        repeat (20) step();
        chk("sat_wide_cnt",  64'(stall_cnt),   64'd24);
        chk("sat_small_cnt", 64'(s_stall_cnt), 64'd15);
        chk("sat_hold_instr", 64'(out_instr),  64'h3C01_ABCD);
        chk("sat_rs",  64'(out_rs),  64'd0);
        chk("sat_rt",  64'(out_rt),  64'd1);
        chk("sat_addr26", 64'(out_addr26), 64'h001_ABCD);

        // Reset during stall with skid full, flush asserted as well
        in_valid = 1'b1; in_instr = 32'h3C02_1234; in_pc = 32'h304;
        step();
        chk("rs_skid_full", 64'(in_ready), 64'd0);
        reset = 1'b1; flush = 1'b1; in_valid = 1'b0;
        step();
        chk("rs_out_valid", 64'(out_valid), 64'd0);
        chk("rs_out_pc",    64'(out_pc),    64'h0);
        chk("rs_in_ready",  64'(in_ready),  64'd1);
        chk("rs_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rs_flush_cnt", 64'(flush_cnt), 64'd0);
        reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
        step();
        chk("rs_no_stale", 64'(out_valid), 64'd0);
        chk("rs_no_stale_instr", 64'(out_instr), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
